issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of 2, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width; tag 0 means "no tag / operand ready".
REQ-003 SHALL have parameter DATA_W, default 32, operand width.
REQ-004 SHALL have parameter OP_W, default 6, opcode width.
REQ-005 SHALL have parameter NCDB, default 2, number of broadcast ports.
REQ-006 SHALL have port clk_in  in  1  the single clock.
REQ-007 SHALL have port rst_in  in  1  synchronous, active-low reset.
REQ-008 SHALL have port rdy_in  in  1  global enable; low freezes all state.
REQ-009 SHALL have port flush_in  in  1  misprediction flush from ROB.
REQ-010 SHALL have ports disp_valid_in in 1 / disp_ready_out out 1  dispatch handshake.
REQ-011 SHALL have ports disp_op_in in OP_W, disp_qj_in/disp_qk_in in TAG_W, disp_vj_in/disp_vk_in/disp_imm_in in DATA_W, disp_dest_in in TAG_W, disp_pc_in in 32  entry payload.
REQ-012 SHALL have ports cdb_tag_in in NCDB*TAG_W, cdb_data_in in NCDB*DATA_W  packed broadcast buses, port k at slice k.
REQ-013 SHALL have ports iss_valid_out out 1 / iss_ready_in in 1  issue handshake.
REQ-014 SHALL have ports iss_op_out OP_W, iss_vj_out/iss_vk_out/iss_imm_out DATA_W, iss_dest_out TAG_W, iss_pc_out 32, all out  issued payload, registered.
REQ-015 SHALL have port count_out  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 SHALL accept a dispatch on a rising edge with rdy_in=1, disp_valid_in=1, disp_ready_out=1, flush_in=0, writing a free entry.
REQ-017 SHALL drive disp_ready_out = (count_out != DEPTH); a slot freed on edge E is reusable from edge E+1 only.
REQ-018 SHALL, on every enabled edge, for each valid entry and each port k with nonzero cdb tag equal to qj (qk), load vj (vk) with cdb data and clear qj (qk).
REQ-019 SHALL apply REQ-018 also to the entry being dispatched, against its incoming disp_qj_in/disp_qk_in.
REQ-020 SHALL, if two CDB ports carry the same nonzero tag, take data from the lowest port index.
REQ-021 SHALL deem an entry ready when qj==0 and qk==0 (dispatcher sets unused operands' tags to 0).
REQ-022 SHALL select the oldest ready entry (earliest accepted dispatch), tracked by per-entry age rank, no starvation.
REQ-023 SHALL load the selected entry into the output register and free it on an edge where iss_valid_out==0 or iss_ready_in==1.
REQ-024 SHALL hold all iss_* outputs stable while iss_valid_out==1 and iss_ready_in==0.
REQ-025 SHALL clear iss_valid_out after a handshake edge with no ready entry.
REQ-026 SHALL have minimum latency: dispatch accepted at edge E with ready operands -> iss_valid_out high after edge E+1.
REQ-027 SHALL keep count_out unchanged on an edge with simultaneous dispatch and issue; otherwise +1/-1.
REQ-028 SHALL, on flush_in=1 (rdy_in=1), invalidate all entries, clear iss_valid_out and count_out next edge; flush has priority over dispatch, wakeup and issue.
REQ-029 SHALL hold all state, including wakeup, when rdy_in=0.

Reset
REQ-030 SHALL, on an edge with rst_in=0 (regardless of rdy_in), invalidate all entries, set count_out=0, iss_valid_out=0, all iss_* data outputs 0, age ranks cleared.
REQ-031 SHALL abandon any in-flight handshake at reset without completing it; disp_ready_out=1 after reset.

Configuration
REQ-032 SHALL, with macro ISSUE_QUEUE_CDB_BYPASS_EN defined, treat an operand whose tag matches a CDB port in the current cycle as ready for selection on that edge, issuing the CDB value.
REQ-033 SHALL, without ISSUE_QUEUE_CDB_BYPASS_EN, make a woken entry selectable no earlier than the edge after wakeup; latency otherwise identical.

Verification
REQ-034 SHALL cover: dispatch op=ADD vj=5 vk=7 qj=qk=0 at edge 1, iss_ready_in=1 -> iss_valid_out=1, iss_vj_out=5, iss_vk_out=7 after edge 2.
REQ-035 SHALL cover: entry qj=3, CDB port 1 tag=3 data=0x1234 at edge 4 -> iss_vj_out=0x1234; valid after edge 4 with bypass, edge 5 without.
REQ-036 SHALL cover: fill 8 entries with qj=2 -> disp_ready_out=0, count_out=8; CDB tag 2 -> issues in dispatch order, count_out decrements to 0.
REQ-037 SHALL cover: iss_ready_in=0 for 3 cycles with iss_valid_out=1 -> iss_* unchanged; later-ready younger entry not overtaking.
REQ-038 SHALL cover: flush_in=1 with count_out=5 and simultaneous disp_valid_in=1 -> count_out=0, iss_valid_out=0 after edge, dispatch dropped.
REQ-039 SHALL cover: rst_in=0 mid-stream with rdy_in=0 -> count_out=0, iss_valid_out=0, disp_ready_out=1.

Source files
------------

// File: rtl/issue_queue_if.sv
// Dispatch, CDB broadcast and issue signals of the issue queue.
// Parameters must match those of the issue_queue instance it is connected to.
interface issue_queue_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int NCDB   = 2
);
    logic                   disp_valid_in;
    logic                   disp_ready_out;
    logic [OP_W-1:0]        disp_op_in;
    logic [TAG_W-1:0]       disp_qj_in;
    logic [TAG_W-1:0]       disp_qk_in;
    logic [DATA_W-1:0]      disp_vj_in;
    logic [DATA_W-1:0]      disp_vk_in;
    logic [DATA_W-1:0]      disp_imm_in;
    logic [TAG_W-1:0]       disp_dest_in;
    logic [31:0]            disp_pc_in;

    logic [NCDB*TAG_W-1:0]  cdb_tag_in;
    logic [NCDB*DATA_W-1:0] cdb_data_in;

    logic                   iss_valid_out;
    logic                   iss_ready_in;
    logic [OP_W-1:0]        iss_op_out;
    logic [DATA_W-1:0]      iss_vj_out;
    logic [DATA_W-1:0]      iss_vk_out;
    logic [DATA_W-1:0]      iss_imm_out;
    logic [TAG_W-1:0]       iss_dest_out;
    logic [31:0]            iss_pc_out;

    modport master (
        output disp_valid_in, disp_op_in, disp_qj_in, disp_qk_in, disp_vj_in, disp_vk_in,
               disp_imm_in, disp_dest_in, disp_pc_in, cdb_tag_in, cdb_data_in, iss_ready_in,
        input  disp_ready_out, iss_valid_out, iss_op_out, iss_vj_out, iss_vk_out,
               iss_imm_out, iss_dest_out, iss_pc_out
    );

    modport slave (
        input  disp_valid_in, disp_op_in, disp_qj_in, disp_qk_in, disp_vj_in, disp_vk_in,
               disp_imm_in, disp_dest_in, disp_pc_in, cdb_tag_in, cdb_data_in, iss_ready_in,
        output disp_ready_out, iss_valid_out, iss_op_out, iss_vj_out, iss_vk_out,
               iss_imm_out, iss_dest_out, iss_pc_out
    );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order issue queue: CDB wakeup, oldest-ready select, registered issue port.
// Define ISSUE_QUEUE_CDB_BYPASS_EN to let a same-cycle CDB match make an entry selectable.

// Single-operand wakeup against all CDB ports; the lowest port index wins a tag collision.
module issue_queue_wakeup #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int NCDB   = 2
) (
    input  logic [TAG_W-1:0]       q_in,
    input  logic [DATA_W-1:0]      v_in,
    input  logic [NCDB*TAG_W-1:0]  cdb_tag,
    input  logic [NCDB*DATA_W-1:0] cdb_data,
    output logic [TAG_W-1:0]       q_out,
    output logic [DATA_W-1:0]      v_out
);
    always_comb begin
        q_out = q_in;
        v_out = v_in;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (q_in != '0 && cdb_tag[k*TAG_W +: TAG_W] == q_in) begin
                q_out = '0;
                v_out = cdb_data[k*DATA_W +: DATA_W];
            end
        end
    end
endmodule

module issue_queue #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int NCDB   = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    issue_queue_if.slave             bus,
    output logic [$clog2(DEPTH):0]   count_out
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0][OP_W-1:0]    op_q, op_d;
    logic [DEPTH-1:0][TAG_W-1:0]   qj_q, qj_d, qk_q, qk_d, dest_q, dest_d;
    logic [DEPTH-1:0][DATA_W-1:0]  vj_q, vj_d, vk_q, vk_d, imm_q, imm_d;
    logic [DEPTH-1:0][31:0]        pc_q, pc_d;
    logic [DEPTH-1:0][IDX_W-1:0]   rank_q, rank_d;
    logic [CNT_W-1:0]              count_q, count_d;

    logic                          iss_valid_q, iss_valid_d;
    logic [OP_W-1:0]               iss_op_q, iss_op_d;
    logic [DATA_W-1:0]             iss_vj_q, iss_vj_d, iss_vk_q, iss_vk_d, iss_imm_q, iss_imm_d;
    logic [TAG_W-1:0]              iss_dest_q, iss_dest_d;
    logic [31:0]                   iss_pc_q, iss_pc_d;

    logic [DEPTH-1:0][TAG_W-1:0]   wqj, wqk;
    logic [DEPTH-1:0][DATA_W-1:0]  wvj, wvk;
    logic [TAG_W-1:0]              dqj, dqk;
    logic [DATA_W-1:0]             dvj, dvk;

    logic [DEPTH-1:0]              sel_ok;
    logic                          sel_found, free_found, disp_fire, iss_adv, iss_take;
    logic [IDX_W-1:0]              sel_idx, sel_rank, free_idx;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_ent
        issue_queue_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NCDB(NCDB)) u_wk_j (
            .q_in(qj_q[gi]), .v_in(vj_q[gi]), .cdb_tag(bus.cdb_tag_in),
            .cdb_data(bus.cdb_data_in), .q_out(wqj[gi]), .v_out(wvj[gi]));
        issue_queue_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NCDB(NCDB)) u_wk_k (
            .q_in(qk_q[gi]), .v_in(vk_q[gi]), .cdb_tag(bus.cdb_tag_in),
            .cdb_data(bus.cdb_data_in), .q_out(wqk[gi]), .v_out(wvk[gi]));
    end

    // The entry being dispatched also snoops the CDB on its way in.
    issue_queue_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NCDB(NCDB)) u_wk_dj (
        .q_in(bus.disp_qj_in), .v_in(bus.disp_vj_in), .cdb_tag(bus.cdb_tag_in),
        .cdb_data(bus.cdb_data_in), .q_out(dqj), .v_out(dvj));
    issue_queue_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NCDB(NCDB)) u_wk_dk (
        .q_in(bus.disp_qk_in), .v_in(bus.disp_vk_in), .cdb_tag(bus.cdb_tag_in),
        .cdb_data(bus.cdb_data_in), .q_out(dqk), .v_out(dvk));

    always_comb begin
        sel_ok = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef ISSUE_QUEUE_CDB_BYPASS_EN
            sel_ok[i] = valid_q[i] && wqj[i] == '0 && wqk[i] == '0;
`else
            sel_ok[i] = valid_q[i] && qj_q[i] == '0 && qk_q[i] == '0;
`endif
        end
    end

    // Rank 0 is the oldest valid entry; ranks stay dense as entries leave.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_rank   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_ok[i] && (!sel_found || rank_q[i] < sel_rank)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_rank  = rank_q[i];
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign disp_fire = bus.disp_valid_in && bus.disp_ready_out && free_found;
    assign iss_adv   = !iss_valid_q || bus.iss_ready_in;

    always_comb begin
        valid_d     = valid_q;
        op_d        = op_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        imm_d       = imm_q;
        dest_d      = dest_q;
        pc_d        = pc_q;
        rank_d      = rank_q;
        count_d     = count_q;
        iss_valid_d = iss_valid_q;
        iss_op_d    = iss_op_q;
        iss_vj_d    = iss_vj_q;
        iss_vk_d    = iss_vk_q;
        iss_imm_d   = iss_imm_q;
        iss_dest_d  = iss_dest_q;
        iss_pc_d    = iss_pc_q;
        iss_take    = 1'b0;
        if (flush_in) begin
            valid_d     = '0;
            rank_d      = '0;
            count_d     = '0;
            iss_valid_d = 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i]) begin
                    qj_d[i] = wqj[i];
                    vj_d[i] = wvj[i];
                    qk_d[i] = wqk[i];
                    vk_d[i] = wvk[i];
                end
            end
            if (iss_adv) begin
                iss_valid_d = sel_found;
                if (sel_found) begin
                    iss_take          = 1'b1;
                    valid_d[sel_idx]  = 1'b0;
                    iss_op_d          = op_q[sel_idx];
                    iss_vj_d          = wvj[sel_idx];
                    iss_vk_d          = wvk[sel_idx];
                    iss_imm_d         = imm_q[sel_idx];
                    iss_dest_d        = dest_q[sel_idx];
                    iss_pc_d          = pc_q[sel_idx];
                    for (int i = 0; i < DEPTH; i++) begin
                        if (valid_q[i] && rank_q[i] > sel_rank)
                            rank_d[i] = rank_q[i] - IDX_W'(1);
                    end
                end
            end
            if (disp_fire) begin
                valid_d[free_idx] = 1'b1;
                op_d[free_idx]    = bus.disp_op_in;
                qj_d[free_idx]    = dqj;
                vj_d[free_idx]    = dvj;
                qk_d[free_idx]    = dqk;
                vk_d[free_idx]    = dvk;
                imm_d[free_idx]   = bus.disp_imm_in;
                dest_d[free_idx]  = bus.disp_dest_in;
                pc_d[free_idx]    = bus.disp_pc_in;
                // Youngest rank counts survivors, excluding the one leaving this edge.
                rank_d[free_idx]  = IDX_W'(count_q - CNT_W'(iss_take));
            end
            count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_take);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q     <= '0;
            op_q        <= '0;
            qj_q        <= '0;
            qk_q        <= '0;
            vj_q        <= '0;
            vk_q        <= '0;
            imm_q       <= '0;
            dest_q      <= '0;
            pc_q        <= '0;
            rank_q      <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_vj_q    <= '0;
            iss_vk_q    <= '0;
            iss_imm_q   <= '0;
            iss_dest_q  <= '0;
            iss_pc_q    <= '0;
        end else if (rdy_in) begin
            valid_q     <= valid_d;
            op_q        <= op_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            imm_q       <= imm_d;
            dest_q      <= dest_d;
            pc_q        <= pc_d;
            rank_q      <= rank_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_vj_q    <= iss_vj_d;
            iss_vk_q    <= iss_vk_d;
            iss_imm_q   <= iss_imm_d;
            iss_dest_q  <= iss_dest_d;
            iss_pc_q    <= iss_pc_d;
        end
    end

    assign bus.disp_ready_out = (count_q != CNT_W'(DEPTH));
    assign bus.iss_valid_out  = iss_valid_q;
    assign bus.iss_op_out     = iss_op_q;
    assign bus.iss_vj_out     = iss_vj_q;
    assign bus.iss_vk_out     = iss_vk_q;
    assign bus.iss_imm_out    = iss_imm_q;
    assign bus.iss_dest_out   = iss_dest_q;
    assign bus.iss_pc_out     = iss_pc_q;
    assign count_out          = count_q;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: wakeup, age ordering, stall, flush, freeze and reset.
module tb_issue_queue;
    localparam int DEPTH = 8, TAG_W = 4, DATA_W = 32, OP_W = 6, NCDB = 2;

    logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
    logic [3:0] count;
    int n_chk = 0, n_fail = 0;

    issue_queue_if #(.TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .NCDB(NCDB)) bus();

    issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .NCDB(NCDB)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .bus(bus), .count_out(count));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.disp_valid_in = 1'b0;
        bus.disp_op_in    = '0;
        bus.disp_qj_in    = '0;
        bus.disp_qk_in    = '0;
        bus.disp_vj_in    = '0;
        bus.disp_vk_in    = '0;
        bus.disp_imm_in   = '0;
        bus.disp_dest_in  = '0;
        bus.disp_pc_in    = '0;
        bus.cdb_tag_in    = '0;
        bus.cdb_data_in   = '0;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                            input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] dest);
        bus.disp_valid_in = 1'b1;
        bus.disp_op_in    = op;
        bus.disp_qj_in    = qj;
        bus.disp_qk_in    = qk;
        bus.disp_vj_in    = vj;
        bus.disp_vk_in    = vk;
        bus.disp_imm_in   = 32'h1000 + 32'(dest);
        bus.disp_dest_in  = dest;
        bus.disp_pc_in    = 32'h400 + 32'(dest) * 4;
    endtask

    task automatic set_cdb(input logic [3:0] t0, input logic [31:0] d0,
                           input logic [3:0] t1, input logic [31:0] d1);
        bus.cdb_tag_in  = {t1, t0};
        bus.cdb_data_in = {d1, d0};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; drive_idle(); bus.iss_ready_in = 1'b0;
        step(); step();
        n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", count); end
        n_chk++; if (bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", bus.iss_valid_out); end
        n_chk++; if (bus.disp_ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_dready: got %b exp 1", bus.disp_ready_out); end
        n_chk++; if (bus.iss_vj_out !== 32'h0) begin n_fail++; $display("FAIL rst_vj: got %0h exp 0", bus.iss_vj_out); end
        n_chk++; if (bus.iss_pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %0h exp 0", bus.iss_pc_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bus.iss_ready_in = 1'b1;
        set_disp(6'd1, 4'd0, 4'd0, 32'd5, 32'd7, 4'd1);
        step(); bus.disp_valid_in = 1'b0;
        n_chk++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count1: got %0d exp 1", count); end
        n_chk++; if (bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b exp 0", bus.iss_valid_out); end
        step();
        n_chk++; if (bus.iss_valid_out !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b exp 1", bus.iss_valid_out); end
        n_chk++; if (bus.iss_vj_out !== 32'd5) begin n_fail++; $display("FAIL basic_vj: got %0h exp 5", bus.iss_vj_out); end
        n_chk++; if (bus.iss_vk_out !== 32'd7) begin n_fail++; $display("FAIL basic_vk: got %0h exp 7", bus.iss_vk_out); end
        n_chk++; if (bus.iss_op_out !== 6'd1) begin n_fail++; $display("FAIL basic_op: got %0h exp 1", bus.iss_op_out); end
        n_chk++; if (bus.iss_imm_out !== 32'h1001) begin n_fail++; $display("FAIL basic_imm: got %0h exp 1001", bus.iss_imm_out); end
        n_chk++; if (bus.iss_pc_out !== 32'h404) begin n_fail++; $display("FAIL basic_pc: got %0h exp 404", bus.iss_pc_out); end
        n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL basic_count0: got %0d exp 0", count); end
        step();
        n_chk++; if (bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b exp 0", bus.iss_valid_out); end
    endtask

    task automatic test_wakeup();
        bus.iss_ready_in = 1'b1;
        set_disp(6'd2, 4'd3, 4'd0, 32'd0, 32'd9, 4'd2);
        step(); bus.disp_valid_in = 1'b0;
        set_cdb(4'd0, 32'h0, 4'd3, 32'h1234);
        step(); set_cdb(4'd0, 32'h0, 4'd0, 32'h0);
`ifndef ISSUE_QUEUE_CDB_BYPASS_EN
        n_chk++; if (bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL wake_nobypass: got %b exp 0", bus.iss_valid_out); end
        step();
`endif
        n_chk++; if (bus.iss_valid_out !== 1'b1) begin n_fail++; $display("FAIL wake_valid: got %b exp 1", bus.iss_valid_out); end
        n_chk++; if (bus.iss_vj_out !== 32'h1234) begin n_fail++; $display("FAIL wake_vj: got %0h exp 1234", bus.iss_vj_out); end
        n_chk++; if (bus.iss_vk_out !== 32'd9) begin n_fail++; $display("FAIL wake_vk: got %0h exp 9", bus.iss_vk_out); end
        n_chk++; if (bus.iss_dest_out !== 4'd2) begin n_fail++; $display("FAIL wake_dest: got %0d exp 2", bus.iss_dest_out); end
        step();
    endtask

    task automatic test_cdb_priority();
        set_disp(6'd3, 4'd5, 4'd0, 32'd0, 32'd4, 4'd3);
        step(); bus.disp_valid_in = 1'b0;
        set_cdb(4'd5, 32'hAAAA, 4'd5, 32'hBBBB);
        step(); set_cdb(4'd0, 32'h0, 4'd0, 32'h0);
`ifndef ISSUE_QUEUE_CDB_BYPASS_EN
        step();
`endif
        n_chk++; if (bus.iss_vj_out !== 32'hAAAA) begin n_fail++; $display("FAIL prio_vj: got %0h exp aaaa", bus.iss_vj_out); end
        n_chk++; if (bus.iss_dest_out !== 4'd3) begin n_fail++; $display("FAIL prio_dest: got %0d exp 3", bus.iss_dest_out); end
        step();
    endtask

    task automatic test_disp_wakeup();
        set_disp(6'd4, 4'd0, 4'd6, 32'h11, 32'd0, 4'd4);
        set_cdb(4'd0, 32'h0, 4'd6, 32'h66);
        step(); drive_idle();
        step();
        n_chk++; if (bus.iss_valid_out !== 1'b1) begin n_fail++; $display("FAIL dwake_valid: got %b exp 1", bus.iss_valid_out); end
        n_chk++; if (bus.iss_vk_out !== 32'h66) begin n_fail++; $display("FAIL dwake_vk: got %0h exp 66", bus.iss_vk_out); end
        n_chk++; if (bus.iss_vj_out !== 32'h11) begin n_fail++; $display("FAIL dwake_vj: got %0h exp 11", bus.iss_vj_out); end
        step();
    endtask

    task automatic test_fill();
        bus.iss_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_disp(6'd5, 4'd2, 4'd0, 32'd0, 32'(i), 4'(i + 1));
            step();
        end
        n_chk++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d exp 8", count); end
        n_chk++; if (bus.disp_ready_out !== 1'b0) begin n_fail++; $display("FAIL fill_dready: got %b exp 0", bus.disp_ready_out); end
        set_disp(6'd5, 4'd0, 4'd0, 32'd0, 32'd99, 4'd9);
        step(); bus.disp_valid_in = 1'b0;
        n_chk++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_overflow: got %0d exp 8", count); end
        set_cdb(4'd2, 32'h22, 4'd0, 32'h0);
        step(); set_cdb(4'd0, 32'h0, 4'd0, 32'h0);
`ifndef ISSUE_QUEUE_CDB_BYPASS_EN
        step();
`endif
        for (int k = 1; k <= 8; k++) begin
            n_chk++; if (bus.iss_dest_out !== 4'(k)) begin n_fail++; $display("FAIL fill_order%0d: got %0d exp %0d", k, bus.iss_dest_out, k); end
            n_chk++; if (bus.iss_vk_out !== 32'(k - 1) || bus.iss_vj_out !== 32'h22) begin n_fail++; $display("FAIL fill_data%0d: got vj %0h vk %0h exp 22 %0h", k, bus.iss_vj_out, bus.iss_vk_out, k - 1); end
            n_chk++; if (count !== 4'(8 - k)) begin n_fail++; $display("FAIL fill_cnt%0d: got %0d exp %0d", k, count, 8 - k); end
            step();
        end
        n_chk++; if (bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b exp 0", bus.iss_valid_out); end
        n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL fill_end: got %0d exp 0", count); end
    endtask

    task automatic test_stall();
        bus.iss_ready_in = 1'b0;
        set_disp(6'd6, 4'd0, 4'd0, 32'hA1, 32'd0, 4'd3);
        step();
        set_disp(6'd6, 4'd4, 4'd0, 32'hB0, 32'd0, 4'd4);
        step();
        n_chk++; if (bus.iss_dest_out !== 4'd3 || bus.iss_valid_out !== 1'b1) begin n_fail++; $display("FAIL stall_first: got %0d/%b exp 3/1", bus.iss_dest_out, bus.iss_valid_out); end
        n_chk++; if (count !== 4'd1) begin n_fail++; $display("FAIL stall_simul: got %0d exp 1", count); end
        set_disp(6'd6, 4'd0, 4'd0, 32'hC1, 32'd0, 4'd5);
        step(); bus.disp_valid_in = 1'b0;
        n_chk++; if (count !== 4'd2) begin n_fail++; $display("FAIL stall_count: got %0d exp 2", count); end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_cdb(4'd4, 32'hB4, 4'd0, 32'h0);
            else        set_cdb(4'd0, 32'h0, 4'd0, 32'h0);
            step();
            n_chk++; if (bus.iss_valid_out !== 1'b1 || bus.iss_dest_out !== 4'd3 || bus.iss_vj_out !== 32'hA1 || bus.iss_op_out !== 6'd6) begin
                n_fail++; $display("FAIL stall_hold%0d: got %b/%0d/%0h exp 1/3/a1", i, bus.iss_valid_out, bus.iss_dest_out, bus.iss_vj_out); end
        end
        set_cdb(4'd0, 32'h0, 4'd0, 32'h0);
        bus.iss_ready_in = 1'b1;
        step();
        n_chk++; if (bus.iss_dest_out !== 4'd4 || bus.iss_vj_out !== 32'hB4) begin n_fail++; $display("FAIL stall_oldest: got %0d/%0h exp 4/b4", bus.iss_dest_out, bus.iss_vj_out); end
        step();
        n_chk++; if (bus.iss_dest_out !== 4'd5 || bus.iss_vj_out !== 32'hC1) begin n_fail++; $display("FAIL stall_young: got %0d/%0h exp 5/c1", bus.iss_dest_out, bus.iss_vj_out); end
        step();
        n_chk++; if (bus.iss_valid_out !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL stall_drain: got %b/%0d exp 0/0", bus.iss_valid_out, count); end
    endtask

    task automatic test_flush();
        bus.iss_ready_in = 1'b0;
        set_disp(6'd7, 4'd0, 4'd0, 32'h77, 32'd0, 4'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            set_disp(6'd7, 4'd7, 4'd0, 32'd0, 32'd0, 4'(i + 2));
            step();
        end
        n_chk++; if (count !== 4'd5 || bus.iss_valid_out !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %0d/%b exp 5/1", count, bus.iss_valid_out); end
        flush = 1'b1;
        set_disp(6'd7, 4'd0, 4'd0, 32'd1, 32'd1, 4'd9);
        step(); flush = 1'b0; bus.disp_valid_in = 1'b0;
        n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d exp 0", count); end
        n_chk++; if (bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", bus.iss_valid_out); end
        n_chk++; if (bus.disp_ready_out !== 1'b1) begin n_fail++; $display("FAIL flush_dready: got %b exp 1", bus.disp_ready_out); end
        set_cdb(4'd7, 32'h70, 4'd0, 32'h0);
        bus.iss_ready_in = 1'b1;
        step(); set_cdb(4'd0, 32'h0, 4'd0, 32'h0);
        step();
        n_chk++; if (count !== 4'd0 || bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %0d/%b exp 0/0", count, bus.iss_valid_out); end
    endtask

    task automatic test_rdy_freeze();
        bus.iss_ready_in = 1'b1;
        set_disp(6'd8, 4'd8, 4'd0, 32'd0, 32'd0, 4'd6);
        step(); bus.disp_valid_in = 1'b0;
        rdy = 1'b0;
        set_cdb(4'd8, 32'h88, 4'd0, 32'h0);
        set_disp(6'd8, 4'd0, 4'd0, 32'd1, 32'd1, 4'd7);
        step(); step();
        rdy = 1'b1; drive_idle();
        n_chk++; if (count !== 4'd1 || bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL frz_hold: got %0d/%b exp 1/0", count, bus.iss_valid_out); end
        step(); step();
        n_chk++; if (count !== 4'd1 || bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL frz_nowake: got %0d/%b exp 1/0", count, bus.iss_valid_out); end
        flush = 1'b1; step(); flush = 1'b0;
        n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL frz_clean: got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid();
        bus.iss_ready_in = 1'b0;
        set_disp(6'd9, 4'd0, 4'd0, 32'h99, 32'd0, 4'd1);
        step();
        set_disp(6'd9, 4'd3, 4'd0, 32'd0, 32'd0, 4'd2);
        step(); bus.disp_valid_in = 1'b0;
        n_chk++; if (count !== 4'd1 || bus.iss_valid_out !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %0d/%b exp 1/1", count, bus.iss_valid_out); end
        rdy = 1'b0; rst_n = 1'b0;
        set_disp(6'd9, 4'd0, 4'd0, 32'd5, 32'd5, 4'd3);
        step();
        n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL rmid_count: got %0d exp 0", count); end
        n_chk++; if (bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b exp 0", bus.iss_valid_out); end
        n_chk++; if (bus.disp_ready_out !== 1'b1) begin n_fail++; $display("FAIL rmid_dready: got %b exp 1", bus.disp_ready_out); end
        n_chk++; if (bus.iss_vj_out !== 32'h0) begin n_fail++; $display("FAIL rmid_vj: got %0h exp 0", bus.iss_vj_out); end
        rst_n = 1'b1; rdy = 1'b1; drive_idle();
        step();
        n_chk++; if (count !== 4'd0 || bus.iss_valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got %0d/%b exp 0/0", count, bus.iss_valid_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_cdb_priority();
        test_disp_wakeup();
        test_fill();
        test_stall();
        test_flush();
        test_rdy_freeze();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
